// File: rtl/convolution_controller.sv
// Frame sequencer for the 3x3 convolution datapath: loads pixels into the
// input FIFO, pops them through the window buffer, collects window results in
// the output FIFO and drains them to the downstream consumer.
module convolution_controller #(
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28,
  parameter int OUT_DEPTH  = 16,
  parameter int CNT_W      = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic in_valid,
  output logic in_ready,
  input  logic out_ready,
  output logic out_valid,
  output logic valid_in,
  output logic pp1,
  output logic oe,
  output logic pp2,
  output logic win_en,
  input  logic full_fifo1,
  input  logic empty_fifo1,
  input  logic ful_fifo2,
  input  logic empty_fifo2,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int OCC_W = $clog2(OUT_DEPTH + 1);
  localparam logic [CNT_W-1:0] TOTAL_PIX = CNT_W'(IMG_WIDTH * IMG_HEIGHT);
  localparam logic [CNT_W-1:0] TOTAL_OUT = CNT_W'((IMG_WIDTH - 2) * (IMG_HEIGHT - 2));
  localparam logic [CNT_W-1:0] LAST_COL  = CNT_W'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] OCC_LIMIT = CNT_W'(OUT_DEPTH);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO       = CNT_W'(2);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    CONV   = 3'd2,
    FLUSH  = 3'd3,
    UNLOAD = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t state, next_state;

  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] col;
  logic [CNT_W-1:0] row;
  logic [CNT_W-1:0] out_cnt;
  logic [OCC_W-1:0] occ;
  logic [CNT_W-1:0] occ_sum;
  logic             tag0;
  logic             tag1;
  logic             push_in;
  logic             pop_in;
  logic             push_out;
  logic             pop_out;
  logic             window_hit;

  // The popped pixel closes a 3x3 window once two full rows and two columns precede it.
  assign window_hit = (row >= TWO) && (col >= TWO);
  assign busy       = (state != IDLE);

  // Next-state decode and FIFO strobes; results still in the tag pipe count against output space.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    push_in    = 1'b0;
    pop_in     = 1'b0;
    pop_out    = 1'b0;
    done       = 1'b0;
    occ_sum    = CNT_W'(occ) + CNT_W'(tag0) + CNT_W'(tag1);
    case (state)
      IDLE: begin
        if (start) next_state = LOAD;
      end
      LOAD: begin
        in_ready = !full_fifo1 && (in_cnt < TOTAL_PIX);
        push_in  = in_valid && in_ready;
        if (full_fifo1 || (in_cnt == TOTAL_PIX)) next_state = CONV;
      end
      CONV: begin
        if (!empty_fifo1 && (occ_sum < OCC_LIMIT)) pop_in = 1'b1;
        else next_state = FLUSH;
      end
      FLUSH: begin
        if (!tag0 && !tag1) next_state = UNLOAD;
      end
      UNLOAD: begin
        pop_out = out_ready && !empty_fifo2;
        if (empty_fifo2 && !out_valid) begin
          if (out_cnt == TOTAL_OUT) next_state = DONE;
          else if (!empty_fifo1)    next_state = CONV;
          else                      next_state = LOAD;
        end
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    push_out = tag1;
    valid_in = push_in || pop_in;
    pp1      = push_in;
    oe       = push_out || pop_out;
    pp2      = push_out;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Frame counters and output occupancy; all cleared on the way back to IDLE.
  always_ff @(posedge clk) begin
    if (reset || (state == DONE)) begin
      in_cnt  <= '0;
      col     <= '0;
      row     <= '0;
      out_cnt <= '0;
      occ     <= '0;
    end else begin
      if (push_in) in_cnt <= in_cnt + ONE;
      if (pop_in) begin
        if (col == LAST_COL) begin
          col <= '0;
          row <= row + ONE;
        end else begin
          col <= col + ONE;
        end
      end
      if (pop_out) out_cnt <= out_cnt + ONE;
      if (push_out && !pop_out)      occ <= occ + OCC_W'(1);
      else if (pop_out && !push_out) occ <= occ - OCC_W'(1);
    end
  end

  // Window shift follows each pop by one cycle; window tags ride two stages to the push.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_en    <= 1'b0;
      tag0      <= 1'b0;
      tag1      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      win_en    <= pop_in;
      tag0      <= pop_in && window_hit;
      tag1      <= tag0;
      out_valid <= pop_out;
    end
  end

  // Sticky error when a push is issued against a full FIFO.
  always_ff @(posedge clk) begin
    if (reset) err <= 1'b0;
    else if ((push_in && full_fifo1) || (push_out && ful_fifo2)) err <= 1'b1;
  end

endmodule

// File: tb/tb_convolution_controller.sv
// Self-checking bench for convolution_controller on a 5x5 frame with a
// 4-entry output FIFO; both datapath FIFOs are modelled in the bench.
module tb_convolution_controller;

  localparam int W  = 5;
  localparam int H  = 5;
  localparam int OD = 4;
  localparam int NOUT = (W - 2) * (H - 2);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic in_ready, out_valid, valid_in, pp1, oe, pp2, win_en;
  logic full_fifo1, empty_fifo1, ful_fifo2, empty_fifo2;
  logic busy, done, err;

  always #5 clk = ~clk;

  convolution_controller #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .OUT_DEPTH(OD), .CNT_W(10)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_ready(out_ready), .out_valid(out_valid),
    .valid_in(valid_in), .pp1(pp1), .oe(oe), .pp2(pp2), .win_en(win_en),
    .full_fifo1(full_fifo1), .empty_fifo1(empty_fifo1),
    .ful_fifo2(ful_fifo2), .empty_fifo2(empty_fifo2),
    .busy(busy), .done(done), .err(err)
  );

  int checks = 0;
  int errors = 0;

  // FIFO models
  int in_depth = 32;
  int in_count = 0;
  int out_count = 0;
  int in_q[$];
  int out_q[$];
  logic force_full2 = 1'b0;
  int m_ni, m_no;

  assign full_fifo1  = (in_count >= in_depth);
  assign empty_fifo1 = (in_count == 0);
  assign ful_fifo2   = (out_count >= OD) || force_full2;
  assign empty_fifo2 = (out_count == 0);

  // Monitor state
  int cyc = 0;
  bit a_in_push, a_in_pop, a_out_push, a_out_pop;
  int a_in_pix, a_out_pix;
  int p1 = -1, p2 = -1, pend = -1;
  bit pend_v = 1'b0;
  bit exp_win, exp_push;
  int frame_acc = 0, frame_out = 0;
  int pop12_cyc = -1, first_push_cyc = -1, first_push_pix = -1;
  bit first_push_err = 1'b0;
  bit seen_unload = 1'b0;
  int last_in_pop_cyc = 0;
  int n_in_push = 0, n_in_pop = 0, n_out_push = 0, n_out_pop = 0, n_out_valid = 0, n_done = 0, n_alt = 0;
  int v_ready_full = 0, v_hs = 0, v_win = 0, v_push = 0, v_ov = 0, v_seq = 0, v_empty = 0;

  // Snapshot taken at the end of an output stall
  int snap_push = 0, snap_quiet = 0;
  logic snap_err = 1'b0;

  // Pixel index of the k-th window result of a frame, in raster order.
  function automatic int exp_win_pix(input int k);
    return (2 + k / (W - 2)) * W + 2 + k % (W - 2);
  endfunction

  function automatic bit is_window_pix(input int p);
    return (p >= 0) && (p / W >= 2) && (p % W >= 2);
  endfunction

  // Sample DUT outputs mid-cycle and compare against the datapath rules.
  always @(negedge clk) begin
    cyc++;
    a_in_push = 1'b0; a_in_pop = 1'b0; a_out_push = 1'b0; a_out_pop = 1'b0;
    a_in_pix = -1; a_out_pix = -1;
    if (reset) begin
      p1 = -1; p2 = -1; pend = -1; pend_v = 1'b0;
      frame_acc = 0; frame_out = 0; seen_unload = 1'b0;
    end else begin
      if (start && !busy) begin
        frame_acc = 0; frame_out = 0; pop12_cyc = -1; first_push_cyc = -1;
        first_push_pix = -1; seen_unload = 1'b0;
      end
      a_in_push  = valid_in && pp1;
      a_in_pop   = valid_in && !pp1;
      a_out_push = oe && pp2;
      a_out_pop  = oe && !pp2;
      if (in_ready && full_fifo1) v_ready_full++;
      if ((in_valid && in_ready) != a_in_push) v_hs++;
      if (a_in_push) begin
        a_in_pix = frame_acc;
        frame_acc++;
        n_in_push++;
        if (seen_unload) n_alt++;
      end
      exp_win  = (p1 >= 0);
      if (win_en != exp_win) v_win++;
      exp_push = is_window_pix(p2);
      if (a_out_push != exp_push) v_push++;
      if (a_out_push) begin
        n_out_push++;
        a_out_pix = p2;
        if (first_push_cyc < 0) begin
          first_push_cyc = cyc; first_push_pix = p2; first_push_err = err;
        end
      end
      p2 = p1;
      p1 = -1;
      if (a_in_pop) begin
        n_in_pop++;
        last_in_pop_cyc = cyc;
        if (in_count > 0) begin
          p1 = in_q[0];
          if (p1 == 12) pop12_cyc = cyc;
        end else begin
          v_empty++;
        end
      end
      if (out_valid != pend_v) v_ov++;
      if (out_valid && pend_v) begin
        n_out_valid++;
        if (pend != exp_win_pix(frame_out)) v_seq++;
        frame_out++;
      end
      pend_v = 1'b0;
      if (a_out_pop) begin
        n_out_pop++;
        seen_unload = 1'b1;
        pend_v = 1'b1;
        if (out_count > 0) pend = out_q[0];
        else begin
          pend = -1;
          v_empty++;
        end
      end
      if (done) n_done++;
    end
  end

  // Registered FIFO occupancy, updated from the actions sampled this cycle.
  always @(posedge clk) begin
    if (reset) begin
      in_count  <= 0;
      out_count <= 0;
      in_q.delete();
      out_q.delete();
    end else begin
      m_ni = in_count;
      m_no = out_count;
      if (a_in_push && m_ni < in_depth) begin in_q.push_back(a_in_pix); m_ni++; end
      if (a_in_pop && in_count > 0) begin void'(in_q.pop_front()); m_ni--; end
      if (a_out_push && m_no < OD) begin out_q.push_back(a_out_pix); m_no++; end
      if (a_out_pop && out_count > 0) begin void'(out_q.pop_front()); m_no--; end
      in_count  <= m_ni;
      out_count <= m_no;
    end
  end

  task automatic run_frame(input int depth, input bit rand_in, input int stall,
                           input bit rand_out, output bit timed_out);
    int done0, push0;
    bit finished;
    in_depth = depth;
    done0 = n_done;
    push0 = n_out_push;
    finished = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; in_valid = 1'b0; out_ready = (stall > 0) ? 1'b0 : 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 3000 && !finished; k++) begin
      if (stall > 0 && k == stall) begin
        snap_push  = n_out_push - push0;
        snap_quiet = cyc - last_in_pop_cyc;
        snap_err   = err;
      end
      in_valid  = (frame_acc < W * H) && (rand_in ? ($urandom_range(0, 3) != 0) : 1'b1);
      out_ready = (k < stall) ? 1'b0 : (rand_out ? ($urandom_range(0, 2) != 0) : 1'b1);
      start     = rand_in && ($urandom_range(0, 15) == 0);
      @(posedge clk); #1;
      if (n_done != done0) finished = 1'b1;
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    timed_out = !finished;
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    int push0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    obs = {in_ready, out_valid, valid_in, pp1, oe, pp2, win_en, busy, done, err};
    checks++;
    if (obs !== 10'b0) begin
      errors++; $display("[TB] FAIL reset_outputs: got %b expected %b", obs, 10'b0);
    end
    push0 = n_in_push;
    in_valid = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (n_in_push != push0) begin
      errors++; $display("[TB] FAIL idle_no_accept: got %0d pushes expected 0", n_in_push - push0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("[TB] FAIL idle_busy: got %b expected 0", busy);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_full_frame();
    bit to;
    int ip0, ipop0, op0, ov0, d0, vs0, vw0, vo0, ve0, vp0;
    ip0 = n_in_push; ipop0 = n_in_pop; op0 = n_out_push; ov0 = n_out_valid; d0 = n_done;
    vs0 = v_seq; vw0 = v_win; vo0 = v_ov; ve0 = v_empty; vp0 = v_push;
    run_frame(32, 1'b0, 0, 1'b0, to);
    @(negedge clk);
    checks++;
    if (to) begin errors++; $display("[TB] FAIL full_frame_timeout: got no done expected done"); end
    checks++;
    if (n_in_push - ip0 != W * H) begin
      errors++; $display("[TB] FAIL full_in_push: got %0d expected %0d", n_in_push - ip0, W * H);
    end
    checks++;
    if (n_in_pop - ipop0 != W * H) begin
      errors++; $display("[TB] FAIL full_in_pop: got %0d expected %0d", n_in_pop - ipop0, W * H);
    end
    checks++;
    if (n_out_push - op0 != NOUT) begin
      errors++; $display("[TB] FAIL full_out_push: got %0d expected %0d", n_out_push - op0, NOUT);
    end
    checks++;
    if (n_out_valid - ov0 != NOUT) begin
      errors++; $display("[TB] FAIL full_out_valid: got %0d expected %0d", n_out_valid - ov0, NOUT);
    end
    checks++;
    if (n_done - d0 != 1) begin
      errors++; $display("[TB] FAIL full_done: got %0d expected 1", n_done - d0);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL full_busy_after: got %b expected 0", busy); end
    checks++;
    if (v_seq - vs0 != 0) begin
      errors++; $display("[TB] FAIL full_out_order: got %0d misordered expected 0", v_seq - vs0);
    end
    checks++;
    if (v_win - vw0 != 0) begin
      errors++; $display("[TB] FAIL full_win_en: got %0d bad cycles expected 0", v_win - vw0);
    end
    checks++;
    if (v_ov - vo0 != 0) begin
      errors++; $display("[TB] FAIL full_out_valid_timing: got %0d bad cycles expected 0", v_ov - vo0);
    end
    checks++;
    if (v_empty - ve0 != 0) begin
      errors++; $display("[TB] FAIL full_empty_pop: got %0d expected 0", v_empty - ve0);
    end
    checks++;
    if (v_push - vp0 != 0) begin
      errors++; $display("[TB] FAIL full_push_timing: got %0d bad cycles expected 0", v_push - vp0);
    end
    checks++;
    if (err !== 1'b0) begin errors++; $display("[TB] FAIL full_err: got %b expected 0", err); end
  endtask

  task automatic test_window_timing();
    bit to;
    int vp0;
    vp0 = v_push;
    run_frame(32, 1'b0, 0, 1'b1, to);
    checks++;
    if (to) begin errors++; $display("[TB] FAIL window_timeout: got no done expected done"); end
    checks++;
    if (pop12_cyc < 0 || first_push_cyc - pop12_cyc != 2) begin
      errors++;
      $display("[TB] FAIL window_latency: got %0d cycles expected 2", first_push_cyc - pop12_cyc);
    end
    checks++;
    if (first_push_pix != 12) begin
      errors++; $display("[TB] FAIL window_first_pix: got %0d expected 12", first_push_pix);
    end
    checks++;
    if (v_push - vp0 != 0) begin
      errors++; $display("[TB] FAIL window_push_rule: got %0d bad cycles expected 0", v_push - vp0);
    end
  endtask

  task automatic test_backpressure();
    bit to;
    int vr0, vh0, ov0, vs0, alt0, ip0;
    vr0 = v_ready_full; vh0 = v_hs; ov0 = n_out_valid; vs0 = v_seq; alt0 = n_alt; ip0 = n_in_push;
    run_frame(8, 1'b1, 0, 1'b1, to);
    checks++;
    if (to) begin errors++; $display("[TB] FAIL bp_timeout: got no done expected done"); end
    checks++;
    if (v_ready_full - vr0 != 0) begin
      errors++; $display("[TB] FAIL bp_ready_while_full: got %0d expected 0", v_ready_full - vr0);
    end
    checks++;
    if (v_hs - vh0 != 0) begin
      errors++; $display("[TB] FAIL bp_handshake: got %0d expected 0", v_hs - vh0);
    end
    checks++;
    if (n_in_push - ip0 != W * H) begin
      errors++; $display("[TB] FAIL bp_in_push: got %0d expected %0d", n_in_push - ip0, W * H);
    end
    checks++;
    if (n_out_valid - ov0 != NOUT) begin
      errors++; $display("[TB] FAIL bp_outputs: got %0d expected %0d", n_out_valid - ov0, NOUT);
    end
    checks++;
    if (v_seq - vs0 != 0) begin
      errors++; $display("[TB] FAIL bp_out_order: got %0d expected 0", v_seq - vs0);
    end
    checks++;
    if (n_alt - alt0 == 0) begin
      errors++; $display("[TB] FAIL bp_alternation: got %0d loads after unload expected >0", n_alt - alt0);
    end
    checks++;
    if (err !== 1'b0) begin errors++; $display("[TB] FAIL bp_err: got %b expected 0", err); end
  endtask

  task automatic test_output_stall();
    bit to;
    int ov0, vs0;
    ov0 = n_out_valid; vs0 = v_seq;
    run_frame(32, 1'b0, 80, 1'b0, to);
    checks++;
    if (to) begin errors++; $display("[TB] FAIL stall_timeout: got no done expected done"); end
    checks++;
    if (snap_push != OD) begin
      errors++; $display("[TB] FAIL stall_pushes: got %0d expected %0d", snap_push, OD);
    end
    checks++;
    if (snap_quiet < 20) begin
      errors++; $display("[TB] FAIL stall_pops_stop: got %0d quiet cycles expected >=20", snap_quiet);
    end
    checks++;
    if (snap_err !== 1'b0) begin errors++; $display("[TB] FAIL stall_err: got %b expected 0", snap_err); end
    checks++;
    if (n_out_valid - ov0 != NOUT) begin
      errors++; $display("[TB] FAIL stall_outputs: got %0d expected %0d", n_out_valid - ov0, NOUT);
    end
    checks++;
    if (v_seq - vs0 != 0) begin
      errors++; $display("[TB] FAIL stall_out_order: got %0d expected 0", v_seq - vs0);
    end
  endtask

  task automatic test_reset_mid_conv();
    bit to, reached;
    int pop0, target, ov0, vs0;
    logic [9:0] obs;
    pop0 = n_in_pop;
    target = $urandom_range(13, 16);
    reached = 1'b0;
    in_depth = 32;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 300 && !reached; k++) begin
      in_valid = (frame_acc < W * H);
      out_ready = 1'b1;
      @(posedge clk); #1;
      if (n_in_pop - pop0 >= target) reached = 1'b1;
    end
    in_valid = 1'b0;
    checks++;
    if (!reached) begin errors++; $display("[TB] FAIL midreset_reach_conv: got %0d pops expected %0d", n_in_pop - pop0, target); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    obs = {in_ready, out_valid, valid_in, pp1, oe, pp2, win_en, busy, done, err};
    checks++;
    if (obs !== 10'b0) begin
      errors++; $display("[TB] FAIL midreset_outputs: got %b expected %b", obs, 10'b0);
    end
    ov0 = n_out_valid; vs0 = v_seq;
    run_frame(32, 1'b0, 0, 1'b1, to);
    checks++;
    if (to) begin errors++; $display("[TB] FAIL midreset_timeout: got no done expected done"); end
    checks++;
    if (n_out_valid - ov0 != NOUT) begin
      errors++; $display("[TB] FAIL midreset_outputs_count: got %0d expected %0d", n_out_valid - ov0, NOUT);
    end
    checks++;
    if (v_seq - vs0 != 0) begin
      errors++; $display("[TB] FAIL midreset_out_order: got %0d expected 0", v_seq - vs0);
    end
  endtask

  task automatic test_err();
    bit to;
    force_full2 = 1'b1;
    run_frame(32, 1'b0, 0, 1'b0, to);
    checks++;
    if (to) begin errors++; $display("[TB] FAIL err_timeout: got no done expected done"); end
    checks++;
    if (first_push_err !== 1'b0) begin
      errors++; $display("[TB] FAIL err_before_push: got %b expected 0", first_push_err);
    end
    checks++;
    if (err !== 1'b1) begin errors++; $display("[TB] FAIL err_set: got %b expected 1", err); end
    force_full2 = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (err !== 1'b1) begin errors++; $display("[TB] FAIL err_sticky: got %b expected 1", err); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin errors++; $display("[TB] FAIL err_cleared: got %b expected 0", err); end
  endtask

  initial begin
    $display("[TB] starting convolution_controller bench");
    test_reset();
    test_full_frame();
    test_window_timing();
    test_backpressure();
    test_output_stall();
    test_reset_mid_conv();
    test_err();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
